// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int HDR_W = 16;

  typedef enum logic [3:0] {
    HDR_HI = 4'd0,
    HDR_LO = 4'd1,
    DAT_HI = 4'd2,
    DAT_LO = 4'd3,
    WRITE  = 4'd4,
    CHK_HI = 4'd5,
    CHK_LO = 4'd6,
    RUN    = 4'd7,
    ERR    = 4'd8
  } state_t;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Packs two consecutive bytes (high first) into a 16-bit word; word_valid
// pulses combinationally on the low-byte transfer.
module byte_assembler
  import prog_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_en,
  input  logic [7:0]       byte_in,
  output logic [HDR_W-1:0] word,
  output logic             word_valid
);

  logic [7:0] hi_q;
  logic       phase_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hi_q    <= '0;
      phase_q <= 1'b0;
    end else if (byte_en) begin
      if (!phase_q) hi_q <= byte_in;
      phase_q <= ~phase_q;
    end
  end

  assign word       = {hi_q, byte_in};
  assign word_valid = byte_en && phase_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: header word N, then N big-endian data words,
// written to consecutive memory words while the CPU is held in reset.
// Optional trailing XOR checksum enabled by PROG_LOADER_CHECKSUM_EN.
//
// state  | meaning
// HDR_HI | waiting for header high byte
// HDR_LO | waiting for header low byte, validates N
// DAT_HI | waiting for data high byte
// DAT_LO | waiting for data low byte
// WRITE  | one-cycle memory write, counter advances
// CHK_HI | waiting for checksum high byte (checksum build only)
// CHK_LO | waiting for checksum low byte, compares (checksum build only)
// RUN    | image loaded, CPU released
// ERR    | bad image, CPU held in reset until restart
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error
);

  state_t            state_q, state_d;
  logic [HDR_W-1:0]  cnt_q;
  logic [HDR_W-1:0]  hdr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [HDR_W-1:0]  word;
  logic              word_valid;
  logic              xfer;
  logic              restart_ok;
  logic              last_word;

  assign xfer       = rx_valid && rx_ready;
  assign restart_ok = restart && (state_q == RUN || state_q == ERR);
  assign last_word  = (cnt_q + HDR_W'(1)) == hdr_q;

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart_ok),
    .byte_en    (xfer),
    .byte_in    (rx_byte),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [HDR_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset || restart_ok)
      csum_q <= '0;
    else if (word_valid && (state_q == HDR_LO || state_q == DAT_LO))
      csum_q <= csum_q ^ word;
  end
`endif

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    case (state_q)
      HDR_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_d = HDR_LO;
      end
      HDR_LO: begin
        rx_ready = 1'b1;
        if (word_valid) begin
          if (word == '0 || word > HDR_W'(MAX_WORDS)) state_d = ERR;
          else                                        state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_d = DAT_LO;
      end
      DAT_LO: begin
        rx_ready = 1'b1;
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        state_d = last_word ? CHK_HI : DAT_HI;
`else
        state_d = last_word ? RUN : DAT_HI;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_d = CHK_LO;
      end
      CHK_LO: begin
        rx_ready = 1'b1;
        if (word_valid) state_d = (word == csum_q) ? RUN : ERR;
      end
`endif
      RUN, ERR: begin
        if (restart) state_d = HDR_HI;
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR_HI;
      cnt_q   <= '0;
      hdr_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (restart_ok) cnt_q <= '0;
      else if (state_q == WRITE) cnt_q <= cnt_q + HDR_W'(1);
      if (state_q == HDR_LO && word_valid) hdr_q <= word;
      if (state_q == DAT_LO && word_valid) wdata_q <= DATA_W'(word);
    end
  end

  // Address wraps modulo 2^ADDR_W by construction of the truncated add.
  assign mem_addr  = ADDR_W'(BASE_ADDR) + cnt_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == WRITE);
  assign cpu_reset = (state_q != RUN);
  assign busy      = (state_q != RUN) && (state_q != ERR);
  assign error     = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default parameters).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_we  = 0;
  int fall_cyc = 0;
  logic cpu_reset_prev = 1'b1;
  logic [21:0] wlog[$];
  logic [21:0] exp_w[$];
  logic [15:0] img[$];

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("ready_vs_write", {31'd0, rx_ready}, {31'd0, busy & ~mem_we});
      if (mem_we) begin
        wlog.push_back({mem_addr, mem_wdata});
        last_we = cyc;
      end
      if (cpu_reset_prev && !cpu_reset) fall_cyc = cyc;
    end
    cpu_reset_prev = cpu_reset;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    step(2);
    reset = 1'b0;
    wlog.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    rx_valid = 1'b1;
    rx_byte  = b;
    k = 0;
    while (!rx_ready && k < 20) begin
      step(1);
      k++;
    end
    check("rx_ready_timeout", k, (k < 20) ? k : 19);
    step(1);
    rx_valid = 1'b0;
    if (gap) step(1);
  endtask

  task automatic send_image(input logic [15:0] words[$], input bit gap);
    logic [15:0] x;
    x = 16'h0;
    foreach (words[i]) begin
      send_byte(words[i][15:8], gap);
      send_byte(words[i][7:0], gap);
      x = x ^ words[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(x[15:8], gap);
    send_byte(x[7:0], gap);
`endif
  endtask

  task automatic expect_writes(input string tag, input logic [21:0] exp[$]);
    check({tag, "_count"}, wlog.size(), exp.size());
    foreach (exp[i])
      if (i < wlog.size()) check({tag, "_entry"}, {10'd0, wlog[i]}, {10'd0, exp[i]});
  endtask

  initial begin
    step(1);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 1);
    check("rst_error", error, 0);
    do_reset();

    // Basic 3-word image, rx_valid held high
    img = '{16'h0003, 16'h1234, 16'hABCD, 16'h0007};
    send_image(img, 1'b0);
    step(3);
    exp_w = '{{6'd0, 16'h1234}, {6'd1, 16'hABCD}, {6'd2, 16'h0007}};
    expect_writes("basic", exp_w);
    check("basic_cpu_reset", cpu_reset, 0);
    check("basic_busy", busy, 0);
    check("basic_error", error, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
    check("basic_release_lat", fall_cyc - last_we, 1);
`endif

    // Same image with rx_valid toggling
    do_reset();
    send_image(img, 1'b1);
    step(3);
    expect_writes("gapped", exp_w);
    check("gapped_cpu_reset", cpu_reset, 0);

    // Zero-length header
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    step(2);
    check("hdr0_error", error, 1);
    check("hdr0_cpu_reset", cpu_reset, 1);
    check("hdr0_busy", busy, 0);
    check("hdr0_rx_ready", rx_ready, 0);
    check("hdr0_writes", wlog.size(), 0);

    // Oversized header 65
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    step(2);
    check("hdr65_error", error, 1);
    check("hdr65_cpu_reset", cpu_reset, 1);
    check("hdr65_writes", wlog.size(), 0);

    // Header 64 is accepted
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    step(2);
    check("hdr64_error", error, 0);
    check("hdr64_busy", busy, 1);
    check("hdr64_rx_ready", rx_ready, 1);

    // Reset after 1.5 words, then a clean 2-word image
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    step(1);
    do_reset();
    check("midrst_addr", mem_addr, 0);
    check("midrst_error", error, 0);
    check("midrst_cpu_reset", cpu_reset, 1);
    img = '{16'h0002, 16'hAABB, 16'hCCDD};
    send_image(img, 1'b0);
    step(3);
    exp_w = '{{6'd0, 16'hAABB}, {6'd1, 16'hCCDD}};
    expect_writes("midrst", exp_w);
    check("midrst_run", cpu_reset, 0);

    // restart from RUN, then a 1-word image
    wlog.delete();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_cpu_reset", cpu_reset, 1);
    check("restart_busy", busy, 1);
    check("restart_addr", mem_addr, 0);
    img = '{16'h0001, 16'hBEEF};
    send_image(img, 1'b0);
    step(3);
    exp_w = '{{6'd0, 16'hBEEF}};
    expect_writes("restart", exp_w);
    check("restart_run", cpu_reset, 0);

    // Full 64-word image
    do_reset();
    img = '{16'h0040};
    for (int i = 0; i < 64; i++) img.push_back(16'(i * 3 + 16'h0100));
    send_image(img, 1'b0);
    step(3);
    check("max_count", wlog.size(), 64);
    if (wlog.size() == 64) begin
      check("max_first", {10'd0, wlog[0]}, {16'd0, 16'h0100});
      check("max_last", {10'd0, wlog[63]}, {10'd0, 6'd63, 16'h0100 + 16'd189});
    end
    check("max_run", cpu_reset, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h31, 1'b0);
    step(2);
    exp_w = '{{6'd0, 16'h1111}, {6'd1, 16'h2222}};
    expect_writes("csum_ok", exp_w);
    check("csum_ok_run", cpu_reset, 0);
    check("csum_ok_error", error, 0);

    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    step(2);
    expect_writes("csum_bad", exp_w);
    check("csum_bad_error", error, 1);
    check("csum_bad_cpu_reset", cpu_reset, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
